// File: rtl/msg_schedule_pkg.sv
// rtl/msg_schedule_pkg.sv - shared SHA-256 schedule constants, types and sigma functions
package msg_schedule_pkg;
  localparam int BLK_SIZE      = 512;
  localparam int WRD_SIZE      = 32;
  localparam int NUM_ROUNDS    = 64;
  localparam int IDX_W         = 6;
  localparam int WORDS_PER_BLK = 16;

  typedef enum logic {IDLE, RUN} state_t;
  typedef logic [WRD_SIZE-1:0] word_t;

  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/msg_schedule_if.sv
// rtl/msg_schedule_if.sv - block load and per-round word handshake bundle
interface msg_schedule_if;
  import msg_schedule_pkg::*;

  logic                i_blk_valid;
  logic                o_blk_ready;
  logic [BLK_SIZE-1:0] i_msg_blk;
  logic                o_w_valid;
  logic                i_round_ready;
  word_t               o_w;
  logic [IDX_W-1:0]    o_round_idx;
  logic                o_last;
  logic                o_done;

  modport slave (
    input  i_blk_valid, i_msg_blk, i_round_ready,
    output o_blk_ready, o_w_valid, o_w, o_round_idx, o_last, o_done
  );

  modport master (
    output i_blk_valid, i_msg_blk, i_round_ready,
    input  o_blk_ready, o_w_valid, o_w, o_round_idx, o_last, o_done
  );
endinterface

// File: rtl/msg_sched_expand.sv
// rtl/msg_sched_expand.sv - combinational next-word expansion for the 16-word window
module msg_sched_expand
  import msg_schedule_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w15
);
  assign w15 = sig1(w14) + w9 + sig0(w1) + w0;
endmodule

// File: rtl/msg_schedule.sv
// rtl/msg_schedule.sv - SHA-256 message schedule: loads a block, streams W0..W63 per round
module msg_schedule
  import msg_schedule_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  msg_schedule_if.slave  bus
);
  state_t                               state, state_nxt;
  logic [WORDS_PER_BLK-1:0][WRD_SIZE-1:0] win;
  logic [IDX_W-1:0]                     t;
  logic                                 done_q;
  logic                                 load, adv, fin;
  logic                                 w_valid;
  word_t                                w_new;

  msg_sched_expand u_expand (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .w15 (w_new)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_blk_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.i_round_ready) begin
          if (t == IDX_W'(NUM_ROUNDS - 1)) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window head is always W[t]; the tail slot receives the expansion of the current window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win    <= '0;
      t      <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        for (int i = 0; i < WORDS_PER_BLK; i++)
          win[i] <= bus.i_msg_blk[BLK_SIZE-1-WRD_SIZE*i -: WRD_SIZE];
        t <= '0;
      end else if (adv) begin
        for (int i = 0; i < WORDS_PER_BLK - 1; i++)
          win[i] <= win[i+1];
        win[WORDS_PER_BLK-1] <= w_new;
        t <= t + 1'b1;
      end else if (fin) begin
        t <= '0;
      end
    end
  end

  assign w_valid         = (state == RUN);
  assign bus.o_blk_ready = (state == IDLE);
  assign bus.o_w_valid   = w_valid;
  assign bus.o_w         = win[0];
  assign bus.o_round_idx = t;
  assign bus.o_last      = w_valid && (t == IDX_W'(NUM_ROUNDS - 1));
  assign bus.o_done      = done_q;
endmodule
